// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory load controller:
// FSM state encoding, default geometry and byte/word widths.
package imem_pkg;

  localparam int unsigned ADDR_W_DEF = 9;   // word-address width (512 words)
  localparam int unsigned CNT_W_DEF  = 16;  // header word count / words_loaded width
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LANE_W     = 2;   // byte-lane index width (4 lanes per word)

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_HDR0 = 3'd1,
    ST_HDR1 = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader byte stream plus instruction-RAM port of the load controller.
//   rx_data/rx_valid : byte source -> controller
//   rx_ready         : controller accepts the byte
//   imem_addr/imem_wdata/imem_we : controller -> instruction RAM
// master = controller side, slave = byte source / RAM side.
interface imem_load_ctrl_if
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;
  logic              imem_we;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_addr, imem_wdata, imem_we
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_addr, imem_wdata, imem_we
  );

endinterface

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes into a little-endian 32-bit word.
//   clk, reset     : clock, synchronous active-high reset
//   clear          : restart at lane 0
//   byte_valid     : a byte is transferred this cycle
//   byte_in        : the byte
//   word_valid_c   : lane-3 byte transferred, word_c is complete (combinational)
//   word_c         : assembled word, lane 0 in bits [7:0]
module imem_byte_packer
  import imem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  logic [LANE_W-1:0]        lane_q;
  logic [WORD_W-BYTE_W-1:0] asm_q;   // lanes 0..2; lane 3 comes straight from byte_in

  // Lane counter and assembly register; lane wraps to 0 after lane 3
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else if (byte_valid) begin
      lane_q <= lane_q + LANE_W'(1);
      case (lane_q)
        2'd0:    asm_q[7:0]   <= byte_in;
        2'd1:    asm_q[15:8]  <= byte_in;
        2'd2:    asm_q[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  assign word_valid_c = byte_valid && (&lane_q);
  assign word_c       = {byte_in, asm_q};

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory load controller: arbitrates the instruction RAM address
// port between CPU fetch (RUN) and a byte-serial loader that streams a
// 2-byte little-endian word count followed by the words themselves.
//   clk, reset   : clock, synchronous active-high reset
//   load_req     : start a load (honoured in RUN only)
//   cpu_pc       : fetch byte address from the core
//   cpu_hold     : stall the core (high in every state but RUN)
//   load_done    : one-cycle pulse in the final cycle of a load
//   load_err     : sticky, a word beyond the RAM was received
//   words_loaded : words actually written in the current/last load
//   bus          : loader byte stream and RAM write port
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_req,
  input  logic [WORD_W-1:0]   cpu_pc,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [CNT_W-1:0]    words_loaded,
  imem_load_ctrl_if.master    bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  n_words_q;    // header word count
  logic [CNT_W-1:0]  word_idx_q;   // words received so far (including overflowed ones)
  logic [ADDR_W-1:0] wptr_q;
  logic              wr_pend_q;    // write cycle of a received word (real or suppressed)
  logic              accept;
  logic              start;
  logic              word_valid_c;
  logic [WORD_W-1:0] word_c;
  logic              ovf_c;
  logic [CNT_W-1:0]  hdr_word_c;
  logic              unused_pc;

  assign unused_pc  = ^{cpu_pc[1:0], cpu_pc[WORD_W-1:ADDR_W+2]};
  assign accept     = bus.rx_valid && bus.rx_ready;
  assign start      = (state_q == ST_RUN) && load_req;
  assign ovf_c      = (word_idx_q >> ADDR_W) != '0;
  assign hdr_word_c = CNT_W'({bus.rx_data, n_words_q[BYTE_W-1:0]});

  imem_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (start),
    .byte_valid   (accept && (state_q == ST_DATA)),
    .byte_in      (bus.rx_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d       = state_q;
    cpu_hold      = 1'b1;
    bus.rx_ready  = 1'b0;
    bus.imem_addr = wptr_q;
    case (state_q)
      ST_RUN: begin
        cpu_hold      = 1'b0;
        bus.imem_addr = cpu_pc[ADDR_W+1:2];
        if (load_req) state_d = ST_HDR0;
      end
      ST_HDR0: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) state_d = ST_HDR1;
      end
      ST_HDR1: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid) state_d = (hdr_word_c == '0) ? ST_DONE : ST_DATA;
      end
      ST_DATA: begin
        // Stop taking bytes once all N words are in; only the last write remains
        bus.rx_ready = (word_idx_q != n_words_q);
        if (wr_pend_q && (word_idx_q == n_words_q)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Header capture, write pipeline, pointers and status
  always_ff @(posedge clk) begin
    if (reset) begin
      n_words_q      <= '0;
      word_idx_q     <= '0;
      wptr_q         <= '0;
      wr_pend_q      <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_wdata <= '0;
      load_done      <= 1'b0;
      load_err       <= 1'b0;
      words_loaded   <= '0;
    end else begin
      wr_pend_q   <= word_valid_c;
      bus.imem_we <= word_valid_c && !ovf_c;
      load_done   <= (state_d == ST_DONE);

      if (word_valid_c) begin
        bus.imem_wdata <= word_c;
        word_idx_q     <= word_idx_q + CNT_W'(1);
        if (ovf_c) load_err <= 1'b1;
      end

      if (bus.imem_we) begin
        wptr_q       <= wptr_q + ADDR_W'(1);
        words_loaded <= words_loaded + CNT_W'(1);
      end

      if ((state_q == ST_HDR0) && accept) n_words_q <= CNT_W'(bus.rx_data);
      if ((state_q == ST_HDR1) && accept) n_words_q <= hdr_word_c;

      if (start) begin
        load_err     <= 1'b0;
        words_loaded <= '0;
        wptr_q       <= '0;
        word_idx_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench: two controllers (512-word and 4-word RAM) driven in lockstep
// by the same loader stream, each with a small RAM model behind it.
module tb_imem_load_ctrl;

  logic        clk;
  logic        reset;
  logic        load_req;
  logic [31:0] cpu_pc;

  logic        cpu_hold_a, load_done_a, load_err_a;
  logic [15:0] words_loaded_a;
  logic        cpu_hold_b, load_done_b, load_err_b;
  logic [15:0] words_loaded_b;

  imem_load_ctrl_if #(.ADDR_W(9)) bus_a ();
  imem_load_ctrl_if #(.ADDR_W(2)) bus_b ();

  imem_load_ctrl #(.ADDR_W(9), .CNT_W(16)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req),
    .cpu_pc       (cpu_pc),
    .cpu_hold     (cpu_hold_a),
    .load_done    (load_done_a),
    .load_err     (load_err_a),
    .words_loaded (words_loaded_a),
    .bus          (bus_a)
  );

  imem_load_ctrl #(.ADDR_W(2), .CNT_W(16)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .load_req     (load_req),
    .cpu_pc       (cpu_pc),
    .cpu_hold     (cpu_hold_b),
    .load_done    (load_done_b),
    .load_err     (load_err_b),
    .words_loaded (words_loaded_b),
    .bus          (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models with write and done-pulse counters
  logic [31:0] ram_a [0:511];
  logic [31:0] ram_b [0:3];
  int wr_cnt_a = 0;
  int wr_cnt_b = 0;
  int done_cnt_a = 0;

  always @(posedge clk) begin
    if (bus_a.imem_we) begin
      ram_a[bus_a.imem_addr] <= bus_a.imem_wdata;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (bus_b.imem_we) begin
      ram_b[bus_b.imem_addr] <= bus_b.imem_wdata;
      wr_cnt_b <= wr_cnt_b + 1;
    end
    if (load_done_a) done_cnt_a <= done_cnt_a + 1;
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input logic v, input logic [7:0] d);
    bus_a.rx_valid = v;
    bus_a.rx_data  = d;
    bus_b.rx_valid = v;
    bus_b.rx_data  = d;
  endtask

  // Present one byte and hold it until the controller takes it
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    set_rx(1'b1, b);
    while (!bus_a.rx_ready && n < 20) begin
      step();
      n++;
    end
    check("rx_ready_wait", 32'(n < 20), 32'd1);
    step();
    set_rx(1'b0, 8'h00);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  // Little-endian word; 'gap' idle cycles between its bytes
  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (i < 3) repeat (gap) step();
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  // Called right after the last data byte: write cycle, DONE, release
  task automatic finish_check(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic [31:0] words);
    check({tag, "_we"},    32'(bus_a.imem_we), 32'd1);
    check({tag, "_waddr"}, 32'(bus_a.imem_addr), addr);
    check({tag, "_wdata"}, bus_a.imem_wdata, data);
    step();
    check({tag, "_done"},      32'(load_done_a), 32'd1);
    check({tag, "_hold_done"}, 32'(cpu_hold_a), 32'd1);
    check({tag, "_words"},     32'(words_loaded_a), words);
    step();
    check({tag, "_done_low"}, 32'(load_done_a), 32'd0);
    check({tag, "_hold_rel"}, 32'(cpu_hold_a), 32'd0);
    check({tag, "_addr_pc"},  32'(bus_a.imem_addr), 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, wbb, db;
    reset    = 1'b1;
    load_req = 1'b0;
    cpu_pc   = 32'h0000_0010;
    set_rx(1'b0, 8'h00);
    repeat (3) step();
    reset = 1'b0;
    step();

    // 1: reset state
    check("rst_addr_a",  32'(bus_a.imem_addr), 32'd4);
    check("rst_addr_b",  32'(bus_b.imem_addr), 32'd0);
    check("rst_hold",    32'(cpu_hold_a), 32'd0);
    check("rst_ready",   32'(bus_a.rx_ready), 32'd0);
    check("rst_done",    32'(load_done_a), 32'd0);
    check("rst_err",     32'(load_err_a), 32'd0);
    check("rst_words",   32'(words_loaded_a), 32'd0);
    check("rst_we",      32'(bus_a.imem_we), 32'd0);

    // 2: two-word load
    wb = wr_cnt_a;
    db = done_cnt_a;
    pulse_load();
    check("s2_hdr0_hold",  32'(cpu_hold_a), 32'd1);
    check("s2_hdr0_ready", 32'(bus_a.rx_ready), 32'd1);
    check("s2_hdr0_addr",  32'(bus_a.imem_addr), 32'd0);
    send_hdr(16'd2);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    finish_check("s2", 32'd1, 32'h0010_0093, 32'd2);
    check("s2_ram0",   ram_a[0], 32'h0000_0013);
    check("s2_ram1",   ram_a[1], 32'h0010_0093);
    check("s2_writes", 32'(wr_cnt_a - wb), 32'd2);
    check("s2_pulses", 32'(done_cnt_a - db), 32'd1);

    // 3: empty image
    wb = wr_cnt_a;
    pulse_load();
    send_hdr(16'd0);
    check("s3_done",   32'(load_done_a), 32'd1);
    check("s3_we",     32'(bus_a.imem_we), 32'd0);
    check("s3_words",  32'(words_loaded_a), 32'd0);
    check("s3_err",    32'(load_err_a), 32'd0);
    step();
    check("s3_hold_rel", 32'(cpu_hold_a), 32'd0);
    check("s3_writes",   32'(wr_cnt_a - wb), 32'd0);

    // 4: five words into the 4-word RAM overflow; the 512-word one does not
    wb  = wr_cnt_a;
    wbb = wr_cnt_b;
    pulse_load();
    send_hdr(16'd5);
    for (int i = 0; i < 5; i++) send_word(32'hA5A5_0000 | 32'(i), 0);
    check("s4_we_a", 32'(bus_a.imem_we), 32'd1);
    check("s4_we_b", 32'(bus_b.imem_we), 32'd0);
    step();
    check("s4_done_b",  32'(load_done_b), 32'd1);
    check("s4_err_b",   32'(load_err_b), 32'd1);
    check("s4_words_b", 32'(words_loaded_b), 32'd4);
    check("s4_err_a",   32'(load_err_a), 32'd0);
    check("s4_words_a", 32'(words_loaded_a), 32'd5);
    step();
    for (int i = 0; i < 4; i++) check("s4_ram_b", ram_b[i], 32'hA5A5_0000 | 32'(i));
    check("s4_ram_a4",    ram_a[4], 32'hA5A5_0004);
    check("s4_writes_b",  32'(wr_cnt_b - wbb), 32'd4);
    check("s4_writes_a",  32'(wr_cnt_a - wb), 32'd5);
    check("s4_err_stick", 32'(load_err_b), 32'd1);
    pulse_load();
    check("s4_err_clr",   32'(load_err_b), 32'd0);
    check("s4_words_clr", 32'(words_loaded_b), 32'd0);
    send_hdr(16'd0);
    step();

    // 5: gappy stream with a load_req mid-load
    wb = wr_cnt_a;
    pulse_load();
    send_hdr(16'd2);
    send_word(32'h0000_0013, 1);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("s5_ignore_ready", 32'(bus_a.rx_ready), 32'd1);
    check("s5_ignore_hold",  32'(cpu_hold_a), 32'd1);
    send_word(32'h0010_0093, 1);
    finish_check("s5", 32'd1, 32'h0010_0093, 32'd2);
    check("s5_ram0",   ram_a[0], 32'h0000_0013);
    check("s5_ram1",   ram_a[1], 32'h0010_0093);
    check("s5_writes", 32'(wr_cnt_a - wb), 32'd2);

    // 6: reset after six data bytes
    wb = wr_cnt_a;
    pulse_load();
    send_hdr(16'd2);
    send_word(32'hDEAD_BEEF, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("s6_hold",    32'(cpu_hold_a), 32'd0);
    check("s6_ready",   32'(bus_a.rx_ready), 32'd0);
    check("s6_words",   32'(words_loaded_a), 32'd0);
    check("s6_addr_pc", 32'(bus_a.imem_addr), 32'd4);
    check("s6_done",    32'(load_done_a), 32'd0);
    step();
    check("s6_ram0",   ram_a[0], 32'hDEAD_BEEF);
    check("s6_ram1",   ram_a[1], 32'h0010_0093);
    check("s6_ram_b0", ram_b[0], 32'hDEAD_BEEF);
    check("s6_writes", 32'(wr_cnt_a - wb), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
